// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyzer: FSM states and default MISR/count constants.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        COMPACT = 3'd2,
        COMPARE = 3'd3,
        RESULT  = 3'd4
    } state_e;

    localparam int          DEF_W         = 16;
    localparam int          DEF_CW        = 8;
    localparam logic [15:0] DEF_POLY      = 16'h1021;
    localparam logic [15:0] DEF_SEED      = 16'hFFFF;
    localparam int          DEF_EXP_COUNT = 90;

endpackage

// File: rtl/bist_response_analyzer_misr16.sv
// Registered multiple-input signature register: load restores the seed, en folds one data word in.
module misr16
    import bist_pkg::*;
#(
    parameter int           W    = DEF_W,
    parameter logic [W-1:0] POLY = DEF_POLY,
    parameter logic [W-1:0] SEED = DEF_SEED
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q, sig_d;

    // Load wins over shift so a restart never mixes in a stale word.
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) sig_q <= SEED;
        else       sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses while RUNNING, then grades signature and cycle count.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int           W         = DEF_W,
    parameter logic [W-1:0] POLY      = DEF_POLY,
    parameter logic [W-1:0] SEED      = DEF_SEED,
    parameter logic [W-1:0] GOLDEN    = '0,
    parameter int           EXP_COUNT = DEF_EXP_COUNT,
    parameter int           CW        = DEF_CW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          INIT,
    input  logic          RUNNING,
    input  logic          FINISH,
    input  logic [W-1:0]  DATA_IN,
    output logic [W-1:0]  SIGNATURE,
    output logic [CW-1:0] CYCLES,
    output logic          DONE,
    output logic          PASS,
    output logic          FAIL,
    output logic          PROTO_ERR
);

    state_e        state_q, state_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          perr_q, perr_d;
    logic          misr_load, misr_en;
    logic          grade_ok;

    misr16 #(.W(W), .POLY(POLY), .SEED(SEED)) u_misr (
        .CLK    (CLK),
        .RESET  (RESET),
        .load_i (misr_load),
        .en_i   (misr_en),
        .data_i (DATA_IN),
        .sig_o  (SIGNATURE)
    );

    // A protocol error seen during the run forces a failing grade.
    assign grade_ok = (SIGNATURE == GOLDEN) && (cycles_q == CW'(EXP_COUNT)) && !perr_q;

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        perr_d    = perr_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        if (INIT) begin
            state_d   = ARMED;
            misr_load = 1'b1;
            cycles_d  = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            perr_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (FINISH) begin
                        perr_d  = 1'b1;
                        state_d = COMPARE;
                    end else if (RUNNING) begin
                        perr_d  = 1'b1;
                    end
                end
                ARMED, COMPACT: begin
                    // The word arriving with FINISH still belongs to the run.
                    if (RUNNING) begin
                        misr_en = 1'b1;
                        state_d = COMPACT;
                        if (cycles_q != '1) cycles_d = cycles_q + CW'(1);
                    end
                    if (FINISH) state_d = COMPARE;
                end
                COMPARE: begin
                    pass_d  = grade_ok;
                    fail_d  = !grade_ok;
                    done_d  = 1'b1;
                    state_d = RESULT;
                    if (RUNNING) perr_d = 1'b1;
                end
                RESULT: begin
                    if (RUNNING || FINISH) perr_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cycles_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            perr_q   <= perr_d;
        end
    end

    assign CYCLES    = cycles_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL      = fail_q;
    assign PROTO_ERR = perr_q;

endmodule
